// File: rtl/word_packer_d2_if.sv
// Handshake and data bundle for word_packer_d2: the upstream beat channel
// (valid/ready, shifted word, length, flush), the fill level fed back to the
// upstream shifter, and the downstream word channel with last/error flags.
interface word_packer_d2_if #(
  parameter int WIDTH     = 196,
  parameter int O_WIDTH   = 128,
  parameter int SHIFT_BIT = 7
);
  // Upstream beat channel
  logic                 i_valid;
  logic                 o_ready;
  logic [WIDTH-1:0]     i_word;
  logic [7:0]           i_len;
  logic                 i_flush;
  logic [SHIFT_BIT-1:0] o_amt;

  // Downstream word channel
  logic                 o_valid;
  logic                 i_ready;
  logic [O_WIDTH-1:0]   o_word;
  logic                 o_last;
  logic                 o_err;

  // Packer side
  modport slave (
    input  i_valid, i_word, i_len, i_flush, i_ready,
    output o_ready, o_amt, o_valid, o_word, o_last, o_err
  );

  // Producer/consumer side
  modport master (
    output i_valid, i_word, i_len, i_flush, i_ready,
    input  o_ready, o_amt, o_valid, o_word, o_last, o_err
  );
endinterface

// File: rtl/word_packer_d2.sv
// Bit packer: accumulates variable-length, pre-shifted upstream fields into a
// WIDTH-bit window and emits O_WIDTH-bit words (bit 0 oldest). A flush request
// drains the partial word zero-padded and tags the final word with o_last.
module word_packer_d2 #(
  parameter int WIDTH     = 196,
  parameter int O_WIDTH   = 128,
  parameter int SHIFT_BIT = 7
) (
  input logic              i_clk,
  input logic              i_rst,
  word_packer_d2_if.slave  bus
);

  // Largest field a single beat may carry; larger lengths are clamped.
  localparam logic [7:0] LEN_MAX = 8'(WIDTH - O_WIDTH);
  localparam logic [8:0] O_W9    = 9'(O_WIDTH);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     buf_q,   buf_d;
  logic [7:0]           fill_q,  fill_d;
  logic [O_WIDTH-1:0]   word_q,  word_d;
  logic                 valid_q, valid_d;
  logic                 last_q,  last_d;
  logic                 err_q,   err_d;

  logic                 ready;
  logic                 accept;
  logic                 flush_acc;
  logic                 emit;
  logic [7:0]           len_eff;
  logic [8:0]           nfill;
  logic [WIDTH-1:0]     merged;

  // Mask keeping only the lowest n bits of an output word, so a padded
  // flush word never carries stray bits above the fill level.
  function automatic logic [O_WIDTH-1:0] low_mask(input logic [7:0] n);
    logic [O_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < O_WIDTH; i++) begin
      if (i < int'(n)) m[i] = 1'b1;
    end
    return m;
  endfunction

  // Handshake qualification and merge arithmetic for the current beat.
  always_comb begin
    ready     = (state_q == RUN) && (!valid_q || bus.i_ready);
    accept    = bus.i_valid && ready;
    flush_acc = bus.i_flush && ready;
    len_eff   = (bus.i_len > LEN_MAX) ? LEN_MAX : bus.i_len;
    merged    = buf_q | bus.i_word;
    nfill     = {1'b0, fill_q} + {1'b0, len_eff};
    emit      = accept && (nfill >= O_W9);
  end

  // Next-state, buffer and output-register update.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_d = state_q;
    buf_d   = buf_q;
    fill_d  = fill_q;
    word_d  = word_q;
    last_d  = last_q;
    err_d   = err_q;
    valid_d = valid_q && !bus.i_ready;

    case (state_q)
      RUN: begin
        if (accept) begin
          if (bus.i_len > LEN_MAX) err_d = 1'b1;
          if (emit) begin
            word_d  = merged[O_WIDTH-1:0];
            valid_d = 1'b1;
            last_d  = 1'b0;
            buf_d   = merged >> O_WIDTH;
            fill_d  = 8'(nfill - O_W9);
          end else begin
            buf_d  = merged;
            fill_d = nfill[7:0];
          end
        end

        // Flush looks at what remains after this beat's merge/emission.
        if (flush_acc) begin
          if (emit) begin
            if (fill_d == 8'd0) last_d  = 1'b1;
            else                state_d = FLUSH;
          end else if (fill_d != 8'd0) begin
            word_d  = buf_d[O_WIDTH-1:0] & low_mask(fill_d);
            valid_d = 1'b1;
            last_d  = 1'b1;
            buf_d   = '0;
            fill_d  = 8'd0;
          end
        end
      end

      FLUSH: begin
        // Wait for the output register to free up, then drain the remainder.
        if (!valid_q || bus.i_ready) begin
          word_d  = buf_q[O_WIDTH-1:0] & low_mask(fill_q);
          valid_d = 1'b1;
          last_d  = 1'b1;
          buf_d   = '0;
          fill_d  = 8'd0;
          state_d = RUN;
        end
      end

      default: state_d = RUN;
    endcase
  end

  // State registers with synchronous reset that overrides any handshake.
  always_ff @(posedge i_clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (i_rst) begin
      state_q <= RUN;
      buf_q   <= '0;
      fill_q  <= 8'd0;
      word_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      fill_q  <= fill_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  assign bus.o_ready = ready;
  assign bus.o_amt   = fill_q[SHIFT_BIT-1:0];
  assign bus.o_valid = valid_q;
  assign bus.o_word  = word_q;
  assign bus.o_last  = last_q;
  assign bus.o_err   = err_q;

endmodule

// File: tb/tb_word_packer_d2.sv
// Directed bench for word_packer_d2: stimulus pushes expected output words
// into a scoreboard queue; a monitor pops and compares on every handshake.
module tb_word_packer_d2;

  localparam int W  = 196;
  localparam int OW = 128;
  localparam int SB = 7;

  typedef struct packed {
    logic [OW-1:0] word;
    logic          last;
  } exp_t;

  logic i_clk = 1'b0;
  logic i_rst;
  int   passed = 0;
  int   total  = 0;
  exp_t sb_q[$];

  word_packer_d2_if #(.WIDTH(W), .O_WIDTH(OW), .SHIFT_BIT(SB)) bus ();

  word_packer_d2 #(.WIDTH(W), .O_WIDTH(OW), .SHIFT_BIT(SB)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else passed++;
  endtask

  // Monitor: a handshake completes on the next rising edge when both are high.
  always @(negedge i_clk) begin
    exp_t e;
    if (!i_rst && bus.o_valid === 1'b1 && bus.i_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_word: got %h, expected no output", bus.o_word);
      end else begin
        e = sb_q.pop_front();
        check("o_word", bus.o_word, e.word);
        check("o_last", bus.o_last, e.last);
      end
    end
  end

  function automatic logic [W-1:0] place(input logic [W-1:0] p, input int sh);
    return p << sh;
  endfunction

  // One beat: drive inputs, let one rising edge pass, return idle 1 after it.
  task automatic beat(input logic [W-1:0] w, input logic [7:0] len,
                      input logic v, input logic fl);
    bus.i_valid = v;
    bus.i_word  = w;
    bus.i_len   = len;
    bus.i_flush = fl;
    @(posedge i_clk); #1;
    bus.i_valid = 1'b0;
    bus.i_word  = '0;
    bus.i_len   = 8'd0;
    bus.i_flush = 1'b0;
  endtask

  task automatic push(input logic [OW-1:0] w, input logic l);
    exp_t e;
    e.word = w;
    e.last = l;
    sb_q.push_back(e);
  endtask

  initial begin
    logic [31:0]   pa, pb, pc, pd;
    logic [63:0]   p1, q1, t1, t2;
    logic [35:0]   p2;
    logic [59:0]   p3;
    logic [39:0]   f40;
    logic [55:0]   q2;
    logic [19:0]   q3;
    logic [67:0]   r68, u1;
    logic [9:0]    s10;
    logic [49:0]   u2;
    logic [OW-1:0] held;
    int            budget;

    pa  = 32'hA0A0_0001; pb = 32'hB1B1_0002; pc = 32'hC2C2_0003; pd = 32'hD3D3_0004;
    p1  = 64'h0123_4567_89AB_CDEF;
    p2  = 36'h9_8765_4321;
    p3  = 60'hFED_CBA9_8765_4321;
    f40 = 40'hAB_CDEF_0123;
    q1  = 64'h1111_2222_3333_4444;
    q2  = 56'h55_6666_7777_8888;
    q3  = 20'hABC_DE;
    r68 = 68'hF_0F0F_1234_5678_9ABC;
    s10 = 10'h3FF;
    u1  = 68'hE_DDDD_CCCC_BBBB_AAAA;
    u2  = 50'h3_1234_5678_9ABC;
    t1  = 64'hCAFE_F00D_DEAD_BEEF;
    t2  = 64'h0BAD_C0DE_FACE_B00C;

    bus.i_valid = 1'b0; bus.i_word = '0; bus.i_len = 8'd0;
    bus.i_flush = 1'b0; bus.i_ready = 1'b1;
    i_rst = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;

    // Reset state
    check("rst_o_valid", bus.o_valid, 1'b0);
    check("rst_o_amt",   bus.o_amt,   7'd0);
    check("rst_o_ready", bus.o_ready, 1'b1);
    check("rst_o_err",   bus.o_err,   1'b0);
    check("rst_o_last",  bus.o_last,  1'b0);
    check("rst_o_word",  bus.o_word,  128'd0);

    // Four 32-bit beats make exactly one word {D,C,B,A}
    beat(place(W'(pa), 0), 8'd32, 1'b1, 1'b0);
    check("amt_after_A", bus.o_amt, 7'd32);
    beat(place(W'(pb), 32), 8'd32, 1'b1, 1'b0);
    check("amt_after_B", bus.o_amt, 7'd64);
    beat(place(W'(pc), 64), 8'd32, 1'b1, 1'b0);
    check("amt_after_C", bus.o_amt, 7'd96);
    push({pd, pc, pb, pa}, 1'b0);
    beat(place(W'(pd), 96), 8'd32, 1'b1, 1'b0);
    check("four_beat_valid", bus.o_valid, 1'b1);
    check("four_beat_amt",   bus.o_amt,   7'd0);
    check("four_beat_last",  bus.o_last,  1'b0);

    // Fill 100, add 60 bits: low 128 out, 32 bits carried into buf[31:0]
    beat(place(W'(p1), 0), 8'd64, 1'b1, 1'b0);
    beat(place(W'(p2), 64), 8'd36, 1'b1, 1'b0);
    check("amt_100", bus.o_amt, 7'd100);
    push({p3[27:0], p2, p1}, 1'b0);
    beat(place(W'(p3), 100), 8'd60, 1'b1, 1'b0);
    check("carry_amt", bus.o_amt, 7'd32);
    // Flushing the carry exposes it at the bottom of the padded word
    push({96'd0, p3[59:28]}, 1'b1);
    beat('0, 8'd0, 1'b0, 1'b1);
    check("carry_flush_amt", bus.o_amt, 7'd0);

    // Fill 40 then flush alone
    beat(place(W'(f40), 0), 8'd40, 1'b1, 1'b0);
    check("amt_40", bus.o_amt, 7'd40);
    push({88'd0, f40}, 1'b1);
    beat('0, 8'd0, 1'b0, 1'b1);
    check("flush40_last", bus.o_last, 1'b1);
    check("flush40_amt",  bus.o_amt,  7'd0);

    // Fill 120, 20-bit beat with flush while downstream stalls
    beat(place(W'(q1), 0), 8'd64, 1'b1, 1'b0);
    beat(place(W'(q2), 64), 8'd56, 1'b1, 1'b0);
    check("amt_120", bus.o_amt, 7'd120);
    held = {q3[7:0], q2, q1};
    push(held, 1'b0);
    push({116'd0, q3[19:8]}, 1'b1);
    bus.i_ready = 1'b0;
    beat(place(W'(q3), 120), 8'd20, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check("stall_valid", bus.o_valid, 1'b1);
      check("stall_word",  bus.o_word,  held);
      check("stall_last",  bus.o_last,  1'b0);
      check("stall_ready", bus.o_ready, 1'b0);
      check("stall_amt",   bus.o_amt,   7'd12);
      // Junk while o_ready is low must be ignored
      bus.i_valid = 1'b1; bus.i_word = {W{1'b1}}; bus.i_len = 8'd5; bus.i_flush = 1'b1;
      @(posedge i_clk); #1;
    end
    bus.i_valid = 1'b0; bus.i_word = '0; bus.i_len = 8'd0; bus.i_flush = 1'b0;
    bus.i_ready = 1'b1;
    @(posedge i_clk); #1;
    check("tail_valid", bus.o_valid, 1'b1);
    check("tail_last",  bus.o_last,  1'b1);
    check("tail_ready", bus.o_ready, 1'b1);
    check("tail_amt",   bus.o_amt,   7'd0);
    @(posedge i_clk); #1;
    check("tail_drained", bus.o_valid, 1'b0);

    // Oversized length: sticky error, merged with 68 bits
    beat(place(W'(r68), 0), 8'd80, 1'b1, 1'b0);
    check("err_set",     bus.o_err, 1'b1);
    check("err_amt",     bus.o_amt, 7'd68);
    push({60'd0, r68}, 1'b1);
    beat('0, 8'd0, 1'b0, 1'b1);
    check("err_sticky1", bus.o_err, 1'b1);
    beat(place(W'(s10), 0), 8'd10, 1'b1, 1'b0);
    check("err_sticky2", bus.o_err, 1'b1);
    check("amt_10",      bus.o_amt, 7'd10);

    // Build a stalled full word, then reset over it; that word is discarded
    bus.i_ready = 1'b0;
    beat(place(W'(u1), 10), 8'd68, 1'b1, 1'b0);
    beat(place(W'(u2), 78), 8'd50, 1'b1, 1'b0);
    check("pre_rst_valid", bus.o_valid, 1'b1);
    i_rst = 1'b1;
    beat(place(W'(s10), 0), 8'd10, 1'b1, 1'b1);
    i_rst = 1'b0;
    check("mid_rst_valid", bus.o_valid, 1'b0);
    check("mid_rst_word",  bus.o_word,  128'd0);
    check("mid_rst_last",  bus.o_last,  1'b0);
    check("mid_rst_err",   bus.o_err,   1'b0);
    check("mid_rst_amt",   bus.o_amt,   7'd0);
    bus.i_ready = 1'b1;

    // Fresh stream after reset carries no stale bits
    beat(place(W'(t1), 0), 8'd64, 1'b1, 1'b0);
    push({t2, t1}, 1'b0);
    beat(place(W'(t2), 64), 8'd64, 1'b1, 1'b0);
    check("post_rst_valid", bus.o_valid, 1'b1);

    // Bounded drain of outstanding expected words
    budget = 0;
    while (sb_q.size() != 0 && budget < 50) begin
      @(posedge i_clk);
      budget++;
    end
    #1;
    check("scoreboard_empty", sb_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
